sr_latch_sequencer: RTL and testbench
=====================================

// Module: sr_latch_sequencer
// PURPOSE
//  Synchronous command front-end that drives a NAND gated SR latch (S, R, en) from a clocked domain.
//  Accepts SET/RESET/TOGGLE/NOP commands over a valid/ready handshake.
//  Sequences setup -> enable pulse -> hold so S and R are never both high and en is never high with S=R=0.
//  Optionally reads Q/Qb back through a synchroniser and flags mismatches.
// PARAMETERS
//  SETUP_CYC   1  cycles S/R are stable with en=0 before en rises; legal range >=1
//  PULSE_CYC   2  cycles en is held high; legal range >=1
//  SETTLE_CYC  1  cycles S/R are held after en falls; legal range >=1
//  CNT_W       4  phase counter width; must hold max(SETUP_CYC, PULSE_CYC, SETTLE_CYC)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  cmd_valid  in   1  command present
//  cmd_op     in   2  00 NOP, 01 SET, 10 RESET, 11 TOGGLE
//  cmd_ready  out  1  high only in IDLE
//  latch_S    out  1  to latch S
//  latch_R    out  1  to latch R
//  latch_en   out  1  to latch en
//  latch_Q    in   1  latch Q (asynchronous to clk)
//  latch_Qb   in   1  latch Qb (asynchronous to clk)
//  state_q    out  1  tracked latch value after the last completed command
//  done       out  1  one-cycle pulse when a command completes
//  err        out  1  one-cycle pulse with done on readback mismatch
// BEHAVIOUR
//  Reset (async): latch_S, latch_R, latch_en, done, err and state_q are 0; cmd_ready is 1; FSM is IDLE.
//   Latch outputs drop immediately, with no clock edge.
//  Reset mid-command: the sequence is abandoned. The latch keeps its physical value, but state_q reads 0.
//  All outputs are registered; no combinational path exists from inputs to outputs.
//  Accept occurs on a cycle with cmd_valid & cmd_ready. cmd_op is captured at accept and ignored afterwards.
//  TOGGLE resolves at accept: SET if state_q==0, otherwise RESET.
//  NOP: done pulses in the cycle after accept; no latch activity; state_q is unchanged.
//  FSM: IDLE -> SETUP -> ENABLE -> HOLD -> [CHECK] -> DONE -> IDLE.
//   SETUP:  drive the target S or R high, en=0, for SETUP_CYC cycles.
//   ENABLE: en=1, S/R unchanged, for PULSE_CYC cycles.
//   HOLD:   en=0, S/R unchanged, for SETTLE_CYC cycles.
//   DONE:   S=R=en=0; done=1 for one cycle; state_q <= target.
//  Latency from accept edge to done-high edge (SET/RESET): 1+SETUP_CYC+PULSE_CYC+SETTLE_CYC, plus 3 if CHECK is compiled in.
//  Invariants, every cycle:
//   !(latch_S & latch_R)
//   latch_en implies (latch_S ^ latch_R)
//   S/R never change while latch_en=1
//  Back-to-back: the earliest next accept is the cycle after DONE. cmd_ready=0 from accept until DONE exits.
//  A repeated SET on a latch already at 1 runs the full sequence (idempotent); done still pulses.
// CONFIGURATION
//  Macro SR_SEQ_READBACK_CHECK_EN.
//   Defined: CHECK state inserted after HOLD. It waits 2 cycles for the 2-flop sync of latch_Q/latch_Qb,
//    then compares on the 3rd cycle. Mismatch (Q!=target or Qb!=~target) gives err=1 alongside done.
//    state_q takes the synced Q value rather than the target.
//   Undefined: no CHECK state and no synchroniser. err is tied to 0; latch_Q/latch_Qb are unused.
// STRUCTURE
//  Package sr_seq_pkg:
//   state enum: IDLE, SETUP, ENABLE, HOLD, CHECK, DONE
//   op codes: OP_NOP, OP_SET, OP_RST, OP_TGL
//   constant SYNC_STAGES=2
//  Sub-module sync_2ff: 1-bit, 2-flop synchroniser with async reset to 0; two instances for Q and Qb.
//  The FSM and the shared phase counter (CNT_W, reloaded on each state entry) live in the top module.
// TESTING
//  1. rst=1 then released; no commands -> cmd_ready=1, all latch outputs 0, state_q=0, done=0.
//  2. SET with defaults -> S=1 for 4 cycles, en high for 2; done at accept+5 (+8 with check); state_q=1.
//  3. TOGGLE twice from state_q=0 -> first drives S (state_q=1), second drives R (state_q=0); R never overlaps S.
//  4. With CHECK, model latch stuck Q=0 during SET -> done and err both pulse at accept+8; state_q=0.
//  5. rst asserted during ENABLE -> latch_en/S/R go to 0 before the next clock edge; FSM IDLE; state_q=0.
//  6. cmd_valid held high with alternating ops -> each accept only when cmd_ready=1; one done per accept.
//   Assertions on all invariants run throughout every test.

Source files
------------

// File: rtl/sr_seq_pkg.sv
// Shared types for the SR latch sequencer: FSM states, command
// op codes, synchroniser depth and TOGGLE target resolution.
package sr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_SET = 2'b01,
    OP_RST = 2'b10,
    OP_TGL = 2'b11
  } op_t;

  localparam int SYNC_STAGES = 2;

  // Value the latch should hold once the command completes.
  // NOP keeps the current value.
  function automatic logic resolve_target(
    input op_t  op,
    input logic cur
  );
    logic t;
    unique case (op)
      OP_SET:  t = 1'b1;
      OP_RST:  t = 1'b0;
      OP_TGL:  t = ~cur;
      default: t = cur;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sr_latch_sequencer_if.sv
// Command handshake and latch-side bundle of the sequencer.
// master: command source / latch model; slave: the sequencer.
interface sr_seq_if;

  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       latch_S;
  logic       latch_R;
  logic       latch_en;
  logic       latch_Q;
  logic       latch_Qb;
  logic       state_q;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd_op,
    output latch_Q, latch_Qb,
    input  cmd_ready,
    input  latch_S, latch_R, latch_en,
    input  state_q, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op,
    input  latch_Q, latch_Qb,
    output cmd_ready,
    output latch_S, latch_R, latch_en,
    output state_q, done, err
  );

endinterface

// File: rtl/sr_latch_sequencer_sync_2ff.sv
// 1-bit two-flop synchroniser, async reset to 0.
// Ports: clk, rst (active-high async), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Clocked front-end driving a NAND gated SR latch: setup, enable
// pulse, hold, optional readback check, then a done pulse.
// Ports: clk, rst (async, active-high), bus (sr_seq_if.slave:
// cmd_valid/cmd_op/cmd_ready, latch_S/R/en, latch_Q/Qb,
// state_q, done, err).
// Build option: SR_SEQ_READBACK_CHECK_EN adds the CHECK state and
// the Q/Qb synchronisers; without it err is 0 and Q/Qb are unused.
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 4
) (
  input  logic    clk,
  input  logic    rst,
  sr_seq_if.slave bus
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             tgt;
  logic             tgt_d;
  logic             last;
  logic             drive;
  logic             s_q;
  logic             r_q;
  logic             en_q;
  logic             done_q;
  logic             rdy_q;
  logic             sq_q;
  op_t              op;

`ifdef SR_SEQ_READBACK_CHECK_EN
  logic q_sync;
  logic qb_sync;
  logic mis;
  logic mis_d;
  logic err_q;

  sync_2ff u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (bus.latch_Q),
    .q   (q_sync)
  );

  sync_2ff u_sync_qb (
    .clk (clk),
    .rst (rst),
    .d   (bus.latch_Qb),
    .q   (qb_sync)
  );
`else
  logic unused_readback;
  assign unused_readback = bus.latch_Q ^ bus.latch_Qb;
`endif

  assign op   = op_t'(bus.cmd_op);
  assign last = (cnt == '0);

  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    tgt_d = tgt;
`ifdef SR_SEQ_READBACK_CHECK_EN
    mis_d = mis;
`endif
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          tgt_d = resolve_target(op, sq_q);
`ifdef SR_SEQ_READBACK_CHECK_EN
          mis_d = 1'b0;
`endif
          if (op == OP_NOP) begin
            nxt = DONE;
          end else begin
            nxt   = SETUP;
            cnt_d = CNT_W'(SETUP_CYC - 1);
          end
        end
      end
      SETUP: begin
        if (last) begin
          nxt   = ENABLE;
          cnt_d = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ENABLE: begin
        if (last) begin
          nxt   = HOLD;
          cnt_d = CNT_W'(SETTLE_CYC - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (last) begin
`ifdef SR_SEQ_READBACK_CHECK_EN
          nxt   = CHECK;
          cnt_d = CNT_W'(SYNC_STAGES);
`else
          nxt   = DONE;
`endif
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
`ifdef SR_SEQ_READBACK_CHECK_EN
      // Two cycles for the synchronisers, compare on the third.
      // The synced Q becomes the tracked value.
      CHECK: begin
        if (last) begin
          nxt   = DONE;
          tgt_d = q_sync;
          mis_d = (q_sync != tgt) || (qb_sync != ~tgt);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign drive = (state == SETUP)
              || (state == ENABLE)
              || (state == HOLD);

  // Latch outputs follow the state one cycle late; ready looks
  // at the next state so it drops on the accept edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tgt    <= 1'b0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b1;
      sq_q   <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_d;
      tgt    <= tgt_d;
      s_q    <= drive & tgt;
      r_q    <= drive & ~tgt;
      en_q   <= (state == ENABLE);
      done_q <= (state == DONE);
      rdy_q  <= (nxt == IDLE);
      if (state == DONE) begin
        sq_q <= tgt;
      end
    end
  end

`ifdef SR_SEQ_READBACK_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis   <= mis_d;
      err_q <= (state == DONE) & mis;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cmd_ready = rdy_q;
  assign bus.latch_S   = s_q;
  assign bus.latch_R   = r_q;
  assign bus.latch_en  = en_q;
  assign bus.done      = done_q;
  assign bus.state_q   = sq_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Scoreboard bench for sr_latch_sequencer: random commands against
// a per-command reference model, plus latch invariant assertions.
module tb_sr_latch_sequencer;
  import sr_seq_pkg::*;

  localparam int SU = 1;
  localparam int PU = 2;
  localparam int ST = 1;
`ifdef SR_SEQ_READBACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LAT = 1 + SU + PU + ST + (CHK ? 3 : 0);

  typedef struct {
    int due;
    bit sq;
    bit err;
    int s_cyc;
    int r_cyc;
    int en_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   m_state = 1'b0;
  bit   stuck = 1'b0;
  logic phys = 1'b0;
  int   s_cnt = 0;
  int   r_cnt = 0;
  int   e_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sr_seq_if bus ();

  sr_latch_sequencer #(
    .SETUP_CYC  (SU),
    .PULSE_CYC  (PU),
    .SETTLE_CYC (ST),
    .CNT_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Physical gated latch; keeps its value through rst.
  always @(bus.latch_en or bus.latch_S or bus.latch_R) begin
    if (bus.latch_en) begin
      if (bus.latch_S && !bus.latch_R) phys = 1'b1;
      else if (bus.latch_R && !bus.latch_S) phys = 1'b0;
    end
  end
  assign bus.latch_Q  = stuck ? 1'b0 : phys;
  assign bus.latch_Qb = ~bus.latch_Q;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: what one accepted command must produce.
  task automatic issue(input int op);
    exp_t e;
    bit   t;
    bit   qa;
    int   n;
    n = SU + PU + ST;
    case (op)
      1:       t = 1'b1;
      2:       t = 1'b0;
      3:       t = !m_state;
      default: t = m_state;
    endcase
    if (op == 0) begin
      e = '{due: cyc + 2, sq: m_state, err: 1'b0,
            s_cyc: 0, r_cyc: 0, en_cyc: 0};
    end else begin
      qa = stuck ? 1'b0 : t;
      e.due    = cyc + 1 + LAT;
      e.sq     = CHK ? qa : t;
      e.err    = CHK && (qa != t);
      e.s_cyc  = t ? n : 0;
      e.r_cyc  = t ? 0 : n;
      e.en_cyc = PU;
    end
    m_state = e.sq;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.latch_S)  s_cnt++;
      if (bus.latch_R)  r_cnt++;
      if (bus.latch_en) e_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("state_q", int'(bus.state_q), int'(e.sq));
          chk("err", int'(bus.err), int'(e.err));
          chk("s_cycles", s_cnt, e.s_cyc);
          chk("r_cycles", r_cnt, e.r_cyc);
          chk("en_cycles", e_cnt, e.en_cyc);
        end
        s_cnt = 0;
        r_cnt = 0;
        e_cnt = 0;
      end
    end
  end

  a_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.latch_S && bus.latch_R))
    else begin errors++; $display("FAIL inv_excl t=%0t", $time); end

  a_en: assert property (@(posedge clk) disable iff (rst)
    bus.latch_en |-> (bus.latch_S ^ bus.latch_R))
    else begin errors++; $display("FAIL inv_en t=%0t", $time); end

  a_hold: assert property (@(posedge clk) disable iff (rst)
    bus.latch_en |=> ($stable(bus.latch_S) && $stable(bus.latch_R)))
    else begin errors++; $display("FAIL inv_hold t=%0t", $time); end

  a_rise: assert property (@(posedge clk) disable iff (rst)
    $rose(bus.latch_en) |-> ($stable(bus.latch_S) && $stable(bus.latch_R)))
    else begin errors++; $display("FAIL inv_rise t=%0t", $time); end

  task automatic send(input int op);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(bus.cmd_ready), 1);
    if (bus.cmd_ready) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'(op);
      issue(op);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("idle_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_S", int'(bus.latch_S), 0);
    chk("rst_R", int'(bus.latch_R), 0);
    chk("rst_en", int'(bus.latch_en), 0);
    chk("rst_state_q", int'(bus.state_q), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);

    send(1);
    wait_idle();
    send(2);
    wait_idle();
    send(3);
    wait_idle();
    send(3);
    wait_idle();
    send(0);
    wait_idle();
    send(1);
    send(1);
    wait_idle();

    if (CHK) begin
      send(2);
      wait_idle();
      stuck = 1'b1;
      send(1);
      wait_idle();
      stuck = 1'b0;
      send(3);
      wait_idle();
    end

    // Reset in the middle of the enable pulse.
    send(2);
    send(1);
    n = 0;
    while (!bus.latch_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("en_seen", int'(bus.latch_en), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_S", int'(bus.latch_S), 0);
    chk("mid_rst_R", int'(bus.latch_R), 0);
    chk("mid_rst_en", int'(bus.latch_en), 0);
    chk("mid_rst_ready", int'(bus.cmd_ready), 1);
    chk("mid_rst_state_q", int'(bus.state_q), 0);
    sb.delete();
    m_state = 1'b0;
    s_cnt = 0;
    r_cnt = 0;
    e_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random ops with cmd_valid often held high.
    for (int i = 0; i < 600; i++) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_op    = 2'($urandom);
      if (bus.cmd_valid && bus.cmd_ready) begin
        issue(int'(bus.cmd_op));
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
